// File: rtl/mem_bus_ctrl.sv
// Memory-bus front end: decodes one CPU load/store at a time to RAM, peripherals or vacant space
// and returns the result on a single-cycle response strobe.
module mem_bus_ctrl #(
   parameter logic [15:0] RAM_BOUND_L = 16'h0200,
   parameter logic [15:0] RAM_BOUND_U = 16'h0400,
   parameter logic [15:0] PER_BOUND_U = 16'h0200,
   parameter int unsigned PER_TIMEOUT = 8,
   parameter logic [15:0] VACANT_DATA = 16'h3FFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   input  logic        req_we,
   input  logic        req_bw,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic [15:0] ram_addr,
   output logic [15:0] ram_Din,
   output logic        ram_RW,
   output logic        BW,
   input  logic [15:0] ram_out,
   output logic [15:0] per_addr,
   output logic [15:0] per_wdata,
   output logic        per_we,
   output logic        per_re,
   output logic        per_bw,
   input  logic [15:0] per_rdata,
   input  logic        per_ack
);

   localparam int unsigned DATA_W = 16;
   localparam int unsigned CNT_W  = (PER_TIMEOUT > 1) ? $clog2(PER_TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RAM_ACC  = 2'd1,
      PER_WAIT = 2'd2,
      RESP     = 2'd3
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   per_cnt;
   logic               cap_we;
   logic               cap_bw;

   logic [DATA_W-1:0]  acc_addr;
   logic               hit_ram;
   logic               hit_per;

   // Word accesses are forced to an even address before decoding
   always_comb begin
      acc_addr = req_bw ? req_addr : {req_addr[DATA_W-1:1], 1'b0};
      hit_ram  = (acc_addr >= RAM_BOUND_L) && (acc_addr < RAM_BOUND_U);
      hit_per  = (acc_addr < PER_BOUND_U);
   end

   assign req_ready = (state == IDLE) && rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         per_cnt   <= '0;
         cap_we    <= 1'b0;
         cap_bw    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         ram_addr  <= '0;
         ram_Din   <= '0;
         ram_RW    <= 1'b0;
         BW        <= 1'b0;
         per_addr  <= '0;
         per_wdata <= '0;
         per_we    <= 1'b0;
         per_re    <= 1'b0;
         per_bw    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               rsp_valid <= 1'b0;
               if (req_valid) begin
                  cap_we <= req_we;
                  cap_bw <= req_bw;
                  if (hit_ram) begin
                     ram_addr <= acc_addr - RAM_BOUND_L;
                     ram_Din  <= req_bw ? {8'h00, req_wdata[7:0]} : req_wdata;
                     BW       <= req_bw;
                     ram_RW   <= req_we;
                     state    <= RAM_ACC;
                  end else if (hit_per) begin
                     per_addr  <= acc_addr;
                     per_wdata <= req_wdata;
                     per_bw    <= req_bw;
                     per_we    <= req_we;
                     per_re    <= ~req_we;
                     per_cnt   <= '0;
                     state     <= PER_WAIT;
                  end else begin
                     // Vacant space: no slave is touched, answer next cycle
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= req_we ? '0 : VACANT_DATA;
                     state     <= RESP;
                  end
               end
            end

            RAM_ACC: begin
               ram_RW    <= 1'b0;
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               if (cap_we)      rsp_rdata <= '0;
               else if (cap_bw) rsp_rdata <= {8'h00, ram_out[7:0]};
               else             rsp_rdata <= ram_out;
               state     <= RESP;
            end

            PER_WAIT: begin
               // An ack arriving on the final allowed cycle still wins over the timeout
               if (per_ack) begin
                  per_we    <= 1'b0;
                  per_re    <= 1'b0;
                  per_cnt   <= '0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  if (cap_we)      rsp_rdata <= '0;
                  else if (cap_bw) rsp_rdata <= {8'h00, per_rdata[7:0]};
                  else             rsp_rdata <= per_rdata;
                  state     <= RESP;
               end else if (per_cnt == CNT_W'(PER_TIMEOUT - 1)) begin
                  per_we    <= 1'b0;
                  per_re    <= 1'b0;
                  per_cnt   <= '0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= cap_we ? '0 : VACANT_DATA;
                  state     <= RESP;
               end else begin
                  per_cnt <= per_cnt + CNT_W'(1);
               end
            end

            RESP: begin
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end

            default: begin
               rsp_valid <= 1'b0;
               ram_RW    <= 1'b0;
               per_we    <= 1'b0;
               per_re    <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with a small byte-addressed RAM model on the RAM port.
module tb_mem_bus_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        req_we;
   logic        req_bw;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_err;
   logic [15:0] ram_addr;
   logic [15:0] ram_Din;
   logic        ram_RW;
   logic        BW;
   logic [15:0] ram_out;
   logic [15:0] per_addr;
   logic [15:0] per_wdata;
   logic        per_we;
   logic        per_re;
   logic        per_bw;
   logic [15:0] per_rdata;
   logic        per_ack;

   int n_vec = 0;
   int n_err = 0;

   mem_bus_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_we    (req_we),
      .req_bw    (req_bw),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .ram_addr  (ram_addr),
      .ram_Din   (ram_Din),
      .ram_RW    (ram_RW),
      .BW        (BW),
      .ram_out   (ram_out),
      .per_addr  (per_addr),
      .per_wdata (per_wdata),
      .per_we    (per_we),
      .per_re    (per_re),
      .per_bw    (per_bw),
      .per_rdata (per_rdata),
      .per_ack   (per_ack)
   );

   always #5 clk = ~clk;

   // Little-endian byte RAM; byte reads return the addressed byte in the low lane
   logic [7:0] mem [0:511];
   logic [8:0] la;
   assign la      = ram_addr[8:0];
   assign ram_out = BW ? {8'h00, mem[la]} : {mem[{la[8:1], 1'b1}], mem[{la[8:1], 1'b0}]};

   always @(posedge clk) begin
      if (ram_RW) begin
         if (BW) begin
            mem[la] <= ram_Din[7:0];
         end else begin
            mem[{la[8:1], 1'b0}] <= ram_Din[7:0];
            mem[{la[8:1], 1'b1}] <= ram_Din[15:8];
         end
      end
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one request and returns 1 time unit after the accept edge (cycle 1)
   task automatic issue(input logic [15:0] a, input logic [15:0] d, input logic we, input logic bw);
      chk("ready_before_req", 16'(req_ready), 16'h1);
      req_addr  = a;
      req_wdata = d;
      req_we    = we;
      req_bw    = bw;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 8'h00;
      rst_n     = 1'b1;
      req_valid = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_we    = 1'b0;
      req_bw    = 1'b0;
      per_rdata = '0;
      per_ack   = 1'b0;

      // Reset state
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ready",     16'(req_ready), 16'h0);
      chk("rst_rsp_valid", 16'(rsp_valid), 16'h0);
      chk("rst_rdata",     rsp_rdata,      16'h0000);
      chk("rst_ram_rw",    16'(ram_RW),    16'h0);
      chk("rst_per_re",    16'(per_re),    16'h0);
      @(negedge clk) rst_n = 1'b1;
      tick();

      // Word write 0x0200 = BEEF
      issue(16'h0200, 16'hBEEF, 1'b1, 1'b0);
      chk("ww_ram_rw",    16'(ram_RW), 16'h1);
      chk("ww_ram_addr",  ram_addr,    16'h0000);
      chk("ww_ram_din",   ram_Din,     16'hBEEF);
      chk("ww_ready_low", 16'(req_ready), 16'h0);
      chk("ww_no_rsp_c1", 16'(rsp_valid), 16'h0);
      tick();
      chk("ww_rsp_valid", 16'(rsp_valid), 16'h1);
      chk("ww_ram_rw_off",16'(ram_RW),    16'h0);
      chk("ww_rdata",     rsp_rdata,      16'h0000);
      chk("ww_err",       16'(rsp_err),   16'h0);
      tick();
      chk("ww_rsp_pulse", 16'(rsp_valid), 16'h0);

      // Word read 0x0200
      issue(16'h0200, 16'h0000, 1'b0, 1'b0);
      chk("wr_ram_rw",    16'(ram_RW), 16'h0);
      tick();
      chk("wr_rsp_valid", 16'(rsp_valid), 16'h1);
      chk("wr_rdata",     rsp_rdata,      16'hBEEF);
      chk("wr_err",       16'(rsp_err),   16'h0);
      tick();

      // Byte write 0x0301 = 0x34
      issue(16'h0301, 16'h1234, 1'b1, 1'b1);
      chk("bw_bw",       16'(BW),     16'h1);
      chk("bw_ram_addr", ram_addr,    16'h0101);
      chk("bw_ram_din",  ram_Din,     16'h0034);
      chk("bw_ram_rw",   16'(ram_RW), 16'h1);
      tick();
      tick();

      // Byte read 0x0301
      issue(16'h0301, 16'h0000, 1'b0, 1'b1);
      tick();
      chk("br_rdata", rsp_rdata, 16'h0034);
      tick();

      // Word read 0x0300: byte lands in upper half
      issue(16'h0300, 16'h0000, 1'b0, 1'b0);
      tick();
      chk("w300_rdata", rsp_rdata, 16'h3400);
      tick();

      // Word read 0x03FF aligns to 0x03FE
      issue(16'h03FF, 16'h0000, 1'b0, 1'b0);
      chk("w3ff_ram_addr", ram_addr, 16'h01FE);
      tick();
      chk("w3ff_rsp_valid", 16'(rsp_valid), 16'h1);
      chk("w3ff_err",       16'(rsp_err),   16'h0);
      tick();

      // Vacant read 0x8000
      issue(16'h8000, 16'h0000, 1'b0, 1'b0);
      chk("vac_rsp_valid", 16'(rsp_valid), 16'h1);
      chk("vac_rdata",     rsp_rdata,      16'h3FFF);
      chk("vac_err",       16'(rsp_err),   16'h1);
      chk("vac_ram_rw",    16'(ram_RW),    16'h0);
      chk("vac_per_re",    16'(per_re),    16'h0);
      tick();
      chk("vac_pulse", 16'(rsp_valid), 16'h0);

      // Vacant write 0xA000 returns zero data with error
      issue(16'hA000, 16'h5555, 1'b1, 1'b0);
      chk("vacw_rdata", rsp_rdata,    16'h0000);
      chk("vacw_err",   16'(rsp_err), 16'h1);
      chk("vacw_per_we",16'(per_we),  16'h0);
      tick();

      // Peripheral read 0x0120, ack in cycle 3
      issue(16'h0120, 16'h0000, 1'b0, 1'b0);
      chk("pr_per_re",   16'(per_re), 16'h1);
      chk("pr_per_we",   16'(per_we), 16'h0);
      chk("pr_per_addr", per_addr,    16'h0120);
      tick();
      tick();
      chk("pr_per_re_c3", 16'(per_re), 16'h1);
      per_ack   = 1'b1;
      per_rdata = 16'hA5A5;
      tick();
      per_ack   = 1'b0;
      chk("pr_rsp_valid", 16'(rsp_valid), 16'h1);
      chk("pr_rdata",     rsp_rdata,      16'hA5A5);
      chk("pr_err",       16'(rsp_err),   16'h0);
      chk("pr_re_drop",   16'(per_re),    16'h0);
      tick();

      // Peripheral read with no ack: 8 wait cycles then timeout
      issue(16'h0120, 16'h0000, 1'b0, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         chk("to_wait_re", 16'(per_re | (16'(rsp_valid) << 1)), 16'h1);
         tick();
      end
      chk("to_rsp_valid", 16'(rsp_valid), 16'h1);
      chk("to_err",       16'(rsp_err),   16'h1);
      chk("to_rdata",     rsp_rdata,      16'h3FFF);
      chk("to_re_drop",   16'(per_re),    16'h0);
      tick();

      // Byte read with ack on the last allowed cycle (cycle 8) succeeds, upper byte masked
      issue(16'h0045, 16'h0000, 1'b0, 1'b1);
      for (int i = 1; i < 8; i++) tick();
      chk("late_per_re", 16'(per_re), 16'h1);
      per_ack   = 1'b1;
      per_rdata = 16'h77C3;
      tick();
      per_ack   = 1'b0;
      chk("late_rsp_valid", 16'(rsp_valid), 16'h1);
      chk("late_err",       16'(rsp_err),   16'h0);
      chk("late_rdata",     rsp_rdata,      16'h00C3);
      tick();

      // Peripheral write acked in cycle 1
      issue(16'h0010, 16'h9876, 1'b1, 1'b0);
      chk("pw_per_we",    16'(per_we), 16'h1);
      chk("pw_per_wdata", per_wdata,   16'h9876);
      per_ack = 1'b1;
      tick();
      per_ack = 1'b0;
      chk("pw_rsp_valid", 16'(rsp_valid), 16'h1);
      chk("pw_rdata",     rsp_rdata,      16'h0000);
      chk("pw_we_drop",   16'(per_we),    16'h0);
      tick();

      // Reset during RAM_ACC of a write
      issue(16'h0210, 16'h1111, 1'b1, 1'b0);
      chk("ab_ram_rw_pre", 16'(ram_RW), 16'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("ab_ram_rw_drop", 16'(ram_RW),    16'h0);
      chk("ab_ready_low",   16'(req_ready), 16'h0);
      @(negedge clk) rst_n = 1'b1;
      tick();
      chk("ab_ready_after", 16'(req_ready), 16'h1);
      chk("ab_no_rsp",      16'(rsp_valid), 16'h0);
      tick();
      chk("ab_no_rsp_2",    16'(rsp_valid), 16'h0);

      // Aborted write must not have reached RAM
      issue(16'h0210, 16'h0000, 1'b0, 1'b0);
      tick();
      chk("ab_rd_valid", 16'(rsp_valid), 16'h1);
      chk("ab_rd_rdata", rsp_rdata,      16'h0000);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
